// File: rtl/wb_rr_arbiter_if.sv
// wb_rr_arbiter_if
//   Bundles the NM-master Wishbone request side, the shared slave side and
//   the grant vector of wb_rr_arbiter.
//   master : view used by the arbiter (it masters the shared slave port)
//   slave  : view used by the surroundings (request masters + slave device)
//   m_*_i  : per-master cyc/stb/we (NM), adr/dat (NM*32), sel (NM*4)
//   m_dat_o/m_ack_o/m_err_o : read data broadcast, per-master ack / error
//   s_*    : single Wishbone slave port; gnt_o : one-hot current owner
interface wb_rr_arbiter_if #(
  parameter int unsigned NM = 2
);
  logic [NM-1:0]    m_cyc_i;
  logic [NM-1:0]    m_stb_i;
  logic [NM-1:0]    m_we_i;
  logic [NM*32-1:0] m_adr_i;
  logic [NM*32-1:0] m_dat_i;
  logic [NM*4-1:0]  m_sel_i;
  logic [31:0]      m_dat_o;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;
  logic             s_cyc_o;
  logic             s_stb_o;
  logic             s_we_o;
  logic [31:0]      s_adr_o;
  logic [31:0]      s_dat_o;
  logic [3:0]       s_sel_o;
  logic             s_ack_i;
  logic [31:0]      s_dat_i;
  logic [NM-1:0]    gnt_o;

  modport master (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
    output m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
           s_sel_o, gnt_o
  );

  modport slave (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
    input  m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
           s_sel_o, gnt_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter
//   Round-robin arbiter sharing one Wishbone slave port between NM masters.
//   Ownership lasts for a whole bus cycle (cyc); a watchdog aborts a transfer
//   whose stb has waited TIMEOUT cycles without ack and reports m_err_o.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : wb_rr_arbiter_if.master (all request, slave and grant signals)
module wb_rr_arbiter #(
  parameter int unsigned NM      = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wb_rr_arbiter_if.master       bus
);
  localparam int unsigned LW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          r_state, w_state_nxt;
  logic [NM-1:0]   r_gnt, w_gnt_nxt;
  logic [LW-1:0]   r_last, w_last_nxt;
  logic [15:0]     r_wdog, w_wdog_nxt;

  logic [LW-1:0]   w_win;
  logic            w_any;
  logic            w_cyc_g, w_stb_g, w_we_g;
  logic [31:0]     w_adr_g, w_dat_g;
  logic [3:0]      w_sel_g;
  logic            w_stall, w_timeout;

  // Round-robin pick: first scan masters above r_last, then wrap to 0..r_last.
  always_comb begin
    w_win = r_last;
    w_any = 1'b0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (!w_any && (i > 32'(r_last)) && bus.m_cyc_i[i]) begin
        w_any = 1'b1;
        w_win = LW'(i);
      end
    end
    for (int unsigned i = 0; i < NM; i++) begin
      if (!w_any && (i <= 32'(r_last)) && bus.m_cyc_i[i]) begin
        w_any = 1'b1;
        w_win = LW'(i);
      end
    end
  end

  // While BUSY, r_last always holds the current owner.
  always_comb begin
    w_cyc_g = 1'b0;
    w_stb_g = 1'b0;
    w_we_g  = 1'b0;
    w_adr_g = '0;
    w_dat_g = '0;
    w_sel_g = '0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (r_last == LW'(i)) begin
        w_cyc_g = bus.m_cyc_i[i];
        w_stb_g = bus.m_stb_i[i];
        w_we_g  = bus.m_we_i[i];
        w_adr_g = bus.m_adr_i[32*i +: 32];
        w_dat_g = bus.m_dat_i[32*i +: 32];
        w_sel_g = bus.m_sel_i[4*i +: 4];
      end
    end
  end

  // A same-cycle ack excludes the stall, so ack beats the timeout.
  assign w_stall   = (r_state == BUSY) && w_cyc_g && w_stb_g && !bus.s_ack_i;
  assign w_timeout = w_stall && (r_wdog == 16'(TIMEOUT - 1));

  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.gnt_o   = r_gnt;

  always_comb begin
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    if (r_state == BUSY) begin
      bus.s_cyc_o = w_cyc_g && !w_timeout;
      bus.s_stb_o = w_cyc_g && w_stb_g && !w_timeout;
      bus.s_we_o  = w_we_g;
      bus.s_adr_o = w_adr_g;
      bus.s_dat_o = w_dat_g;
      bus.s_sel_o = w_sel_g;
      bus.m_ack_o = r_gnt & {NM{bus.s_ack_i && w_cyc_g}};
      bus.m_err_o = r_gnt & {NM{w_timeout}};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    w_wdog_nxt  = '0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = BUSY;
          w_gnt_nxt   = NM'(1) << w_win;
          w_last_nxt  = w_win;
        end
      end
      BUSY: begin
        if (!w_cyc_g || w_timeout) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
        end else if (w_stall) begin
          w_wdog_nxt = r_wdog + 16'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_last  <= LW'(NM - 1);
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_last  <= w_last_nxt;
      r_wdog  <= w_wdog_nxt;
    end
  end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter
//   Self-checking bench for wb_rr_arbiter (NM=2, TIMEOUT=8). Masters are
//   driven by tasks, a latency-programmable slave model answers, and a
//   monitor compares slave-side traffic and grant order against queues
//   filled when the stimulus is issued.
module tb_wb_rr_arbiter;
  localparam int unsigned NM  = 2;
  localparam int unsigned TO  = 8;
  localparam logic [31:0] RDK   = 32'hA5A5_0000;
  localparam logic [31:0] STALL = 32'hDEAD_0000;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    bit          err;
  } txn_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_rr_arbiter_if #(.NM(NM)) bus();

  wb_rr_arbiter #(.NM(NM), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   lat    = 2;
  txn_t sbq[NM][$];
  int   exp_gnt[$];

  // Slave model: read data derived from address; never acks STALL.
  assign bus.s_dat_i = bus.s_adr_o ^ RDK;

  initial begin
    int w;
    w = 0;
    bus.s_ack_i = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.s_cyc_o && bus.s_stb_o && !bus.s_ack_i && bus.s_adr_o != STALL) w++;
      else w = 0;
      @(posedge clk);
      #2;
      bus.s_ack_i = (w >= lat);
    end
  end

  // Monitor: slave-side scoreboard and grant-order scoreboard.
  logic [NM-1:0] prev_gnt = '0;
  always @(negedge clk) begin
    int   gi;
    int   e;
    txn_t t;
    if (!rst_n) begin
      prev_gnt = '0;
    end else begin
      if ((bus.m_ack_o | bus.m_err_o) != '0) begin
        gi = 0;
        for (int i = 0; i < NM; i++) if (bus.m_ack_o[i] | bus.m_err_o[i]) gi = i;
        checks++;
        if ((bus.m_ack_o | bus.m_err_o) !== bus.gnt_o) begin
          errors++;
          $display("FAIL route: ack|err=%b gnt=%b", bus.m_ack_o | bus.m_err_o, bus.gnt_o);
        end
        checks++;
        if (sbq[gi].size() == 0) begin
          errors++;
          $display("FAIL sb_empty: master %0d response with no expected txn", gi);
        end else begin
          t = sbq[gi].pop_front();
          if (bus.m_err_o[gi] !== t.err) begin
            errors++;
            $display("FAIL sb_err m%0d: got %b expected %b", gi, bus.m_err_o[gi], t.err);
          end else if (t.err) begin
            checks++;
            if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin
              errors++;
              $display("FAIL err_cyc: s_cyc=%b s_stb=%b expected 0 0", bus.s_cyc_o, bus.s_stb_o);
            end
          end else begin
            checks++;
            if (bus.s_adr_o !== t.adr || bus.s_we_o !== t.we || bus.s_sel_o !== t.sel ||
                (t.we && bus.s_dat_o !== t.dat)) begin
              errors++;
              $display("FAIL sb_txn m%0d: adr=%h we=%b sel=%h dat=%h expected adr=%h we=%b sel=%h dat=%h",
                       gi, bus.s_adr_o, bus.s_we_o, bus.s_sel_o, bus.s_dat_o,
                       t.adr, t.we, t.sel, t.dat);
            end
          end
        end
      end
      if (bus.gnt_o !== prev_gnt) begin
        checks++;
        if (prev_gnt != '0 && bus.gnt_o != '0) begin
          errors++;
          $display("FAIL gnt_gap: gnt %b -> %b expected an idle cycle between", prev_gnt, bus.gnt_o);
        end
        if (bus.gnt_o != '0) begin
          gi = 0;
          for (int i = 0; i < NM; i++) if (bus.gnt_o[i]) gi = i;
          checks++;
          if (exp_gnt.size() == 0) begin
            errors++;
            $display("FAIL gnt_unexp: got grant to m%0d expected none", gi);
          end else begin
            e = exp_gnt.pop_front();
            if (gi != e || bus.gnt_o !== (NM'(1) << e)) begin
              errors++;
              $display("FAIL gnt_order: got %b expected m%0d", bus.gnt_o, e);
            end
          end
        end
      end
      prev_gnt = bus.gnt_o;
    end
  end

  task automatic clear_masters();
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i  = '0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.m_sel_i = '0;
  endtask

  task automatic drive_req(input int mi, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel, input bit err);
    txn_t t;
    bus.m_cyc_i[mi] = 1'b1;
    bus.m_stb_i[mi] = 1'b1;
    bus.m_we_i[mi]  = we;
    bus.m_adr_i[32*mi +: 32] = adr;
    bus.m_dat_i[32*mi +: 32] = dat;
    bus.m_sel_i[4*mi +: 4]   = sel;
    t.we = we; t.adr = adr; t.dat = dat; t.sel = sel; t.err = err;
    sbq[mi].push_back(t);
  endtask

  task automatic drop_req(input int mi);
    bus.m_cyc_i[mi] = 1'b0;
    bus.m_stb_i[mi] = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_masters();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Read sequence: single reads drop cyc between transfers, bursts hold it.
  task automatic run_master(input int mi, input int n, input bit burst, input logic [31:0] base);
    logic [31:0] adr;
    bit          got;
    @(posedge clk); #2;
    bus.m_cyc_i[mi] = 1'b1;
    for (int k = 0; k < n; k++) begin
      adr = base + 32'(4 * k);
      drive_req(mi, 1'b0, adr, 32'h0, 4'hF, 1'b0);
      got = 1'b0;
      for (int t = 0; t < 300 && !got; t++) begin
        @(negedge clk);
        if (bus.m_ack_o[mi]) begin
          got = 1'b1;
          checks++;
          if (bus.m_dat_o !== (adr ^ RDK)) begin
            errors++;
            $display("FAIL rd_data m%0d: got %h expected %h", mi, bus.m_dat_o, adr ^ RDK);
          end
        end
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL ack_wait m%0d: no ack within 300 cycles", mi);
      end
      @(posedge clk); #2;
      bus.m_stb_i[mi] = 1'b0;
      if (!burst) begin
        bus.m_cyc_i[mi] = 1'b0;
        if (k + 1 < n) begin
          @(posedge clk); #2;
          bus.m_cyc_i[mi] = 1'b1;
        end
      end
    end
    bus.m_cyc_i[mi] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_masters();
    #12;
    checks++;
    if (bus.gnt_o !== '0 || bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0 ||
        bus.m_ack_o !== '0 || bus.m_err_o !== '0) begin
      errors++;
      $display("FAIL reset: gnt=%b cyc=%b stb=%b ack=%b err=%b expected all 0",
               bus.gnt_o, bus.s_cyc_o, bus.s_stb_o, bus.m_ack_o, bus.m_err_o);
    end
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.gnt_o !== '0 || bus.s_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: gnt=%b cyc=%b expected 0 0", bus.gnt_o, bus.s_cyc_o);
    end
  endtask

  task automatic test_single_write();
    int  k;
    bit  got;
    lat = 2;
    exp_gnt.push_back(0);
    @(posedge clk); #2;
    drive_req(0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.s_cyc_o !== 1'b0 || bus.gnt_o !== 2'b00) begin
      errors++;
      $display("FAIL arb_cycle: s_cyc=%b gnt=%b expected 0 00", bus.s_cyc_o, bus.gnt_o);
    end
    @(negedge clk);
    checks++;
    if (bus.s_cyc_o !== 1'b1 || bus.s_stb_o !== 1'b1 || bus.s_we_o !== 1'b1 ||
        bus.s_adr_o !== 32'h100 || bus.s_dat_o !== 32'hDEAD_BEEF || bus.s_sel_o !== 4'hF ||
        bus.gnt_o !== 2'b01) begin
      errors++;
      $display("FAIL mirror: cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h gnt=%b expected 1 1 1 100 deadbeef f 01",
               bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_adr_o, bus.s_dat_o, bus.s_sel_o, bus.gnt_o);
    end
    got = 1'b0;
    k = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      k++;
      if (bus.m_ack_o != '0) begin
        got = 1'b1;
        checks++;
        if (bus.m_ack_o !== 2'b01 || k != 2) begin
          errors++;
          $display("FAIL wr_ack: ack=%b after %0d cycles expected 01 after 2", bus.m_ack_o, k);
        end
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL wr_ack_wait: no ack within 20 cycles");
    end
    @(posedge clk); #2;
    drop_req(0);
    bus.m_we_i[0] = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_rr_alternate();
    apply_reset();
    lat = 1;
    for (int i = 0; i < 6; i++) exp_gnt.push_back(i % 2);
    fork
      run_master(0, 3, 1'b0, 32'h0000_1000);
      run_master(1, 3, 1'b0, 32'h0000_2000);
    join
    repeat (3) @(posedge clk);
    checks++;
    if (exp_gnt.size() != 0) begin
      errors++;
      $display("FAIL rr_grants: %0d grants missing expected 0", exp_gnt.size());
    end
  endtask

  task automatic test_no_preempt();
    lat = 2;
    exp_gnt.push_back(1);
    exp_gnt.push_back(0);
    fork
      run_master(1, 4, 1'b1, 32'h0000_3000);
      begin
        repeat (3) @(posedge clk);
        run_master(0, 1, 1'b0, 32'h0000_4000);
      end
    join
    repeat (3) @(posedge clk);
    checks++;
    if (exp_gnt.size() != 0) begin
      errors++;
      $display("FAIL preempt_grants: %0d grants missing expected 0", exp_gnt.size());
    end
  endtask

  task automatic test_timeout();
    int n;
    bit got;
    lat = 2;
    exp_gnt.push_back(0);
    exp_gnt.push_back(1);
    fork
      begin
        @(posedge clk); #2;
        drive_req(0, 1'b0, STALL, 32'h0, 4'hF, 1'b1);
        n = 0;
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
          @(negedge clk);
          if (bus.gnt_o[0]) n++;
          if (bus.m_err_o[0]) begin
            got = 1'b1;
            checks++;
            if (n != TO || bus.s_cyc_o !== 1'b0 || bus.m_ack_o !== 2'b00) begin
              errors++;
              $display("FAIL timeout: err after %0d cycles cyc=%b ack=%b expected %0d 0 00",
                       n, bus.s_cyc_o, bus.m_ack_o, TO);
            end
          end
        end
        if (!got) begin
          checks++; errors++;
          $display("FAIL timeout_wait: no m_err_o[0] within 50 cycles");
        end
        @(posedge clk); #2;
        drop_req(0);
      end
      begin
        repeat (2) @(posedge clk);
        run_master(1, 1, 1'b0, 32'h0000_5000);
      end
    join
    repeat (3) @(posedge clk);
    checks++;
    if (exp_gnt.size() != 0) begin
      errors++;
      $display("FAIL timeout_grants: %0d grants missing expected 0", exp_gnt.size());
    end
  endtask

  task automatic test_ack_at_timeout();
    int n;
    bit got;
    lat = 7;
    exp_gnt.push_back(0);
    @(posedge clk); #2;
    drive_req(0, 1'b0, 32'h0000_6000, 32'h0, 4'h3, 1'b0);
    n = 0;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (bus.gnt_o[0]) n++;
      if (bus.m_ack_o != '0 || bus.m_err_o != '0) begin
        got = 1'b1;
        checks++;
        if (n != TO || bus.m_ack_o !== 2'b01 || bus.m_err_o !== 2'b00 ||
            bus.m_dat_o !== (32'h6000 ^ RDK)) begin
          errors++;
          $display("FAIL ack_wins: n=%0d ack=%b err=%b dat=%h expected %0d 01 00 %h",
                   n, bus.m_ack_o, bus.m_err_o, bus.m_dat_o, TO, 32'h6000 ^ RDK);
        end
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_wins_wait: no response within 50 cycles");
    end
    @(posedge clk); #2;
    drop_req(0);
    lat = 2;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen;
    exp_gnt.push_back(0);
    @(posedge clk); #2;
    drive_req(0, 1'b0, STALL, 32'h0, 4'hF, 1'b1);
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (bus.s_cyc_o) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_start: s_cyc_o=%b expected 1 before reset", bus.s_cyc_o);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0 || bus.gnt_o !== '0 ||
        bus.m_ack_o !== '0 || bus.m_err_o !== '0) begin
      errors++;
      $display("FAIL async_reset: cyc=%b stb=%b gnt=%b ack=%b err=%b expected all 0",
               bus.s_cyc_o, bus.s_stb_o, bus.gnt_o, bus.m_ack_o, bus.m_err_o);
    end
    sbq[0].delete();
    clear_masters();
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    clear_masters();
    test_reset();
    test_single_write();
    test_rr_alternate();
    test_no_preempt();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid();
    checks++;
    if (exp_gnt.size() != 0 || sbq[0].size() != 0 || sbq[1].size() != 0) begin
      errors++;
      $display("FAIL leftovers: gnt=%0d m0=%0d m1=%0d expected 0 0 0",
               exp_gnt.size(), sbq[0].size(), sbq[1].size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL global_timeout: bench did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "time limit");
  end
endmodule
